// File: rtl/multi_channel_accumulator_if.sv
// Sample-stream and SPI pin bundle for multi_channel_accumulator.
// The master side drives samples and the SPI host pins; the slave side returns miso.
interface multi_channel_accumulator_if #(
  parameter int CH_COUNT = 2,
  parameter int SAMPLE_W = 12
);
  logic [CH_COUNT*SAMPLE_W-1:0] sample;
  logic [CH_COUNT-1:0]          sample_ovf;
  logic                         en;
  logic                         sck;
  logic                         mosi;
  logic                         cs;
  logic                         miso;

  modport master (
    output sample, sample_ovf, en, sck, mosi, cs,
    input  miso
  );

  modport slave (
    input  sample, sample_ovf, en, sck, mosi, cs,
    output miso
  );
endinterface

// File: rtl/multi_channel_accumulator.sv
// CH_COUNT-channel sample accumulator with sticky ovf/sat flags and an atomic SPI mode-0 snapshot.
// Optional CLEAR_ON_READ_EN: accumulators and counter restart in the snapshot cycle.
module multi_channel_accumulator #(
  parameter int CH_COUNT = 2,
  parameter int SAMPLE_W = 12,
  parameter int ACC_W    = 32,
  parameter int CNT_W    = 24
) (
  input  logic                        i_acc_clk,
  input  logic                        i_reset,
  multi_channel_accumulator_if.slave  io_bus,
  output logic                        o_led_1,
  output logic                        o_led_2,
  output logic                        o_led_3
);

  localparam int FRAME_W = CNT_W + CH_COUNT*ACC_W + 2*CH_COUNT;
  localparam int PTR_W   = $clog2(FRAME_W + 1);
  localparam logic [PTR_W-1:0] PTR_END = PTR_W'(FRAME_W);

  // state   | meaning
  // S_IDLE  | no frame; sck ignored, miso low
  // S_SNAP  | one cycle: load shadow frame, clear sticky flags
  // S_SHIFT | shadow MSB on miso, shift on each synchronised sck fall
  typedef enum logic [1:0] {S_IDLE, S_SNAP, S_SHIFT} state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_snap;
  logic   w_restart;

  logic [2:0] r_sck_sync;
  logic [2:0] r_cs_sync;
  logic [1:0] r_mosi_sync_unused;
  logic       w_sck_fall;
  logic       w_cs_fall;
  logic       w_cs_rise;

  logic [ACC_W-1:0]    r_acc [CH_COUNT];
  logic [CNT_W-1:0]    r_cnt;
  logic [CH_COUNT-1:0] r_ovf;
  logic [CH_COUNT-1:0] r_sat;
  logic                r_seen;

  logic [SAMPLE_W-1:0] w_samp [CH_COUNT];
  logic [ACC_W:0]      w_sum  [CH_COUNT];
  logic [CH_COUNT-1:0] w_sat_set;
  logic [FRAME_W-1:0]  w_frame;

  logic [FRAME_W-1:0]  r_shadow;
  logic [PTR_W-1:0]    r_ptr;

  always_ff @(posedge i_acc_clk) begin
    if (i_reset) begin
      r_sck_sync         <= '0;
      r_cs_sync          <= '0;
      r_mosi_sync_unused <= '0;
    end else begin
      r_sck_sync         <= {r_sck_sync[1:0], io_bus.sck};
      r_cs_sync          <= {r_cs_sync[1:0], io_bus.cs};
      r_mosi_sync_unused <= {r_mosi_sync_unused[0], io_bus.mosi};
    end
  end

  assign w_sck_fall = r_sck_sync[2] & ~r_sck_sync[1];
  assign w_cs_fall  = r_cs_sync[2]  & ~r_cs_sync[1];
  assign w_cs_rise  = ~r_cs_sync[2] &  r_cs_sync[1];

  always_ff @(posedge i_acc_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_snap      = 1'b0;
    case (r_state)
      S_IDLE:  if (w_cs_fall) w_state_nxt = S_SNAP;
      S_SNAP: begin
        w_snap      = 1'b1;
        w_state_nxt = w_cs_rise ? S_IDLE : S_SHIFT;
      end
      S_SHIFT: if (w_cs_rise) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef CLEAR_ON_READ_EN
  assign w_restart = w_snap;
`else
  assign w_restart = 1'b0;
`endif

  always_comb begin
    w_sat_set = '0;
    for (int c = 0; c < CH_COUNT; c++) begin
      w_samp[c]    = io_bus.sample[c*SAMPLE_W +: SAMPLE_W];
      w_sum[c]     = {1'b0, r_acc[c]} + (ACC_W+1)'(w_samp[c]);
      w_sat_set[c] = io_bus.en & w_sum[c][ACC_W] & ~w_restart;
    end
  end

  // A restart replaces the running totals with this cycle's sample so nothing is lost or counted twice.
  always_ff @(posedge i_acc_clk) begin
    if (i_reset) begin
      for (int c = 0; c < CH_COUNT; c++) r_acc[c] <= '0;
      r_cnt <= '0;
    end else if (w_restart) begin
      for (int c = 0; c < CH_COUNT; c++) r_acc[c] <= io_bus.en ? ACC_W'(w_samp[c]) : '0;
      r_cnt <= io_bus.en ? CNT_W'(1) : '0;
    end else if (io_bus.en) begin
      for (int c = 0; c < CH_COUNT; c++) r_acc[c] <= w_sum[c][ACC_W] ? '1 : w_sum[c][ACC_W-1:0];
      if (!(&r_cnt)) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge i_acc_clk) begin
    if (i_reset) begin
      r_ovf  <= '0;
      r_sat  <= '0;
      r_seen <= 1'b0;
    end else begin
      r_ovf  <= (w_snap ? '0 : r_ovf) | (io_bus.en ? io_bus.sample_ovf : '0);
      r_sat  <= (w_snap ? '0 : r_sat) | w_sat_set;
      r_seen <= (~w_snap & r_seen) | io_bus.en;
    end
  end

  always_comb begin
    w_frame = '0;
    w_frame[FRAME_W-1 -: CNT_W] = r_cnt;
    for (int c = 0; c < CH_COUNT; c++) w_frame[2*CH_COUNT + c*ACC_W +: ACC_W] = r_acc[c];
    w_frame[2*CH_COUNT-1 -: CH_COUNT] = r_ovf;
    w_frame[CH_COUNT-1:0]             = r_sat;
  end

  // Zero fill on shift means miso reads 0 once every frame bit has gone out.
  always_ff @(posedge i_acc_clk) begin
    if (i_reset) begin
      r_shadow <= '0;
      r_ptr    <= '0;
    end else if (w_snap) begin
      r_shadow <= w_frame;
      r_ptr    <= '0;
    end else if (r_state == S_SHIFT && w_sck_fall && r_ptr < PTR_END) begin
      r_shadow <= {r_shadow[FRAME_W-2:0], 1'b0};
      r_ptr    <= r_ptr + PTR_W'(1);
    end
  end

  assign io_bus.miso = (r_state == S_SHIFT) & r_shadow[FRAME_W-1] & ~io_bus.cs;
  assign o_led_1     = r_seen;
  assign o_led_2     = (|r_ovf) | (|r_sat);
  assign o_led_3     = (r_state != S_IDLE);

endmodule

// File: tb/tb_multi_channel_accumulator.sv
// Directed bench: default-width DUT and a narrow (ACC_W=16, CNT_W=8) DUT share stimulus; frames are decoded per field.
module tb_multi_channel_accumulator;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multi_channel_accumulator_if #(.CH_COUNT(2), .SAMPLE_W(12)) bus_a ();
  multi_channel_accumulator_if #(.CH_COUNT(2), .SAMPLE_W(12)) bus_b ();

  assign bus_b.sample     = bus_a.sample;
  assign bus_b.sample_ovf = bus_a.sample_ovf;
  assign bus_b.en         = bus_a.en;
  assign bus_b.sck        = bus_a.sck;
  assign bus_b.mosi       = bus_a.mosi;
  assign bus_b.cs         = bus_a.cs;

  logic a_led1, a_led2, a_led3, b_led1, b_led2, b_led3;

  multi_channel_accumulator dut_a (
    .i_acc_clk (clk), .i_reset (rst), .io_bus (bus_a),
    .o_led_1 (a_led1), .o_led_2 (a_led2), .o_led_3 (a_led3)
  );

  multi_channel_accumulator #(.ACC_W(16), .CNT_W(8)) dut_b (
    .i_acc_clk (clk), .i_reset (rst), .io_bus (bus_b),
    .o_led_1 (b_led1), .o_led_2 (b_led2), .o_led_3 (b_led3)
  );

  typedef struct {
    int          n;
    logic [11:0] ch0, ch1;
    logic [1:0]  ovf;
    logic        a_led1, a_led2, b_led2;
    logic [23:0] a_cnt;
    logic [31:0] a_acc0, a_acc1;
    logic [1:0]  x_ovf, a_sat;
    logic [7:0]  b_cnt;
    logic [15:0] b_acc0, b_acc1;
    logic [1:0]  b_sat;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  logic [95:0] cap_a, cap_b;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input int n, input logic [11:0] ch0, input logic [11:0] ch1, input logic [1:0] ovf);
    if (n > 0) begin
      bus_a.sample     = {ch1, ch0};
      bus_a.sample_ovf = ovf;
      bus_a.en         = 1'b1;
      cycles(n);
    end
    bus_a.en         = 1'b0;
    bus_a.sample     = '0;
    bus_a.sample_ovf = '0;
    cycles(1);
  endtask

  // Leaves cs low; spi_end closes the frame.
  task automatic spi_read(input int nbits, input bit inject);
    int guard;
    guard    = 0;
    bus_a.cs = 1'b0;
    cycles(1);
    while (!a_led3 && guard < 20) begin
      cycles(1);
      guard++;
    end
    chk("frame_start_led3", 96'(a_led3), 96'(1'b1));
    if (inject) begin
      bus_a.en     = 1'b1;
      bus_a.sample = {12'h000, 12'h005};
      cycles(1);
      bus_a.en     = 1'b0;
      bus_a.sample = '0;
    end else begin
      cycles(1);
    end
    cap_a = '0;
    cap_b = '0;
    for (int i = 0; i < nbits; i++) begin
      cycles(8);
      cap_a[95-i] = bus_a.miso;
      cap_b[95-i] = bus_b.miso;
      bus_a.sck = 1'b1;
      cycles(8);
      bus_a.sck = 1'b0;
    end
  endtask

  task automatic spi_end();
    bus_a.cs = 1'b1;
    cycles(8);
    chk("frame_end_led3", 96'(a_led3), 96'(1'b0));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [6];
    vec_t v;
    logic [23:0] e_cnt;
    logic [31:0] e_acc0, e_acc1;
    logic [7:0]  e_b8a, e_bcnt;

`ifdef CLEAR_ON_READ_EN
    vt[0] = '{10,  12'h0FF, 12'h001, 2'b00, 1'b1, 1'b0, 1'b0, 24'd10,  32'h9F6,   32'hA,    2'b00, 2'b00, 8'd10,  16'h9F6,  16'hA,    2'b00};
    vt[1] = '{1,   12'h000, 12'h000, 2'b10, 1'b1, 1'b1, 1'b1, 24'd1,   32'h0,     32'h0,    2'b10, 2'b00, 8'd1,   16'h0,    16'h0,    2'b00};
    vt[2] = '{0,   12'h000, 12'h000, 2'b00, 1'b0, 1'b0, 1'b0, 24'd0,   32'h0,     32'h0,    2'b00, 2'b00, 8'd0,   16'h0,    16'h0,    2'b00};
    vt[3] = '{20,  12'hFFF, 12'h000, 2'b00, 1'b1, 1'b0, 1'b1, 24'd20,  32'h13FEC, 32'h0,    2'b00, 2'b00, 8'd20,  16'hFFFF, 16'h0,    2'b01};
    vt[4] = '{250, 12'h000, 12'h100, 2'b00, 1'b1, 1'b0, 1'b0, 24'd250, 32'h0,     32'hFA00, 2'b00, 2'b00, 8'd250, 16'h0,    16'hFA00, 2'b00};
    vt[5] = '{3,   12'h001, 12'h800, 2'b00, 1'b1, 1'b0, 1'b0, 24'd3,   32'h3,     32'h1800, 2'b00, 2'b00, 8'd3,   16'h3,    16'h1800, 2'b00};
`else
    vt[0] = '{10,  12'h0FF, 12'h001, 2'b00, 1'b1, 1'b0, 1'b0, 24'd10,    32'h9F6,   32'hA,     2'b00, 2'b00, 8'd10,  16'h9F6,  16'hA,    2'b00};
    vt[1] = '{1,   12'h000, 12'h000, 2'b10, 1'b1, 1'b1, 1'b1, 24'd11,    32'h9F6,   32'hA,     2'b10, 2'b00, 8'd11,  16'h9F6,  16'hA,    2'b00};
    vt[2] = '{0,   12'h000, 12'h000, 2'b00, 1'b0, 1'b0, 1'b0, 24'd11,    32'h9F6,   32'hA,     2'b00, 2'b00, 8'd11,  16'h9F6,  16'hA,    2'b00};
    vt[3] = '{20,  12'hFFF, 12'h000, 2'b00, 1'b1, 1'b0, 1'b1, 24'd31,    32'h149E2, 32'hA,     2'b00, 2'b00, 8'd31,  16'hFFFF, 16'hA,    2'b01};
    vt[4] = '{250, 12'h000, 12'h100, 2'b00, 1'b1, 1'b0, 1'b0, 24'h119,   32'h149E2, 32'hFA0A,  2'b00, 2'b00, 8'hFF,  16'hFFFF, 16'hFA0A, 2'b00};
    vt[5] = '{3,   12'h001, 12'h800, 2'b00, 1'b1, 1'b0, 1'b1, 24'h11C,   32'h149E5, 32'h1120A, 2'b00, 2'b00, 8'hFF,  16'hFFFF, 16'hFFFF, 2'b11};
`endif

    rst              = 1'b1;
    bus_a.cs         = 1'b1;
    bus_a.sck        = 1'b0;
    bus_a.mosi       = 1'b0;
    bus_a.en         = 1'b0;
    bus_a.sample     = '0;
    bus_a.sample_ovf = '0;
    cycles(3);
    chk("rst_a_leds", 96'({a_led1, a_led2, a_led3}), 96'(3'b000));
    chk("rst_b_leds", 96'({b_led1, b_led2, b_led3}), 96'(3'b000));
    chk("rst_miso",   96'({bus_a.miso, bus_b.miso}), 96'(2'b00));
    rst = 1'b0;
    cycles(4);
    chk("post_rst_leds", 96'({a_led1, a_led2, a_led3}), 96'(3'b000));

    for (int i = 0; i < 6; i++) begin
      v = vt[i];
      drive(v.n, v.ch0, v.ch1, v.ovf);
      chk($sformatf("v%0d_a_led1", i), 96'(a_led1), 96'(v.a_led1));
      chk($sformatf("v%0d_a_led2", i), 96'(a_led2), 96'(v.a_led2));
      chk($sformatf("v%0d_b_led2", i), 96'(b_led2), 96'(v.b_led2));
      spi_read(96, 1'b0);
      chk($sformatf("v%0d_a_led1_after", i), 96'(a_led1), 96'(1'b0));
      spi_end();
      chk($sformatf("v%0d_a_cnt", i),  96'(cap_a[95:72]), 96'(v.a_cnt));
      chk($sformatf("v%0d_a_acc1", i), 96'(cap_a[71:40]), 96'(v.a_acc1));
      chk($sformatf("v%0d_a_acc0", i), 96'(cap_a[39:8]),  96'(v.a_acc0));
      chk($sformatf("v%0d_a_ovf", i),  96'(cap_a[7:6]),   96'(v.x_ovf));
      chk($sformatf("v%0d_a_sat", i),  96'(cap_a[5:4]),   96'(v.a_sat));
      chk($sformatf("v%0d_a_tail", i), 96'(cap_a[3:0]),   96'(4'h0));
      chk($sformatf("v%0d_b_cnt", i),  96'(cap_b[95:88]), 96'(v.b_cnt));
      chk($sformatf("v%0d_b_acc1", i), 96'(cap_b[87:72]), 96'(v.b_acc1));
      chk($sformatf("v%0d_b_acc0", i), 96'(cap_b[71:56]), 96'(v.b_acc0));
      chk($sformatf("v%0d_b_ovf", i),  96'(cap_b[55:54]), 96'(v.x_ovf));
      chk($sformatf("v%0d_b_sat", i),  96'(cap_b[53:52]), 96'(v.b_sat));
      chk($sformatf("v%0d_b_tail", i), 96'(cap_b[51:0]),  96'(52'h0));
    end

    // Sample of 5 lands exactly in the snapshot cycle: excluded from this read, included in the next.
`ifdef CLEAR_ON_READ_EN
    e_cnt = 24'd0;    e_acc0 = 32'h0;       e_acc1 = 32'h0;
`else
    e_cnt = 24'h11C;  e_acc0 = 32'h149E5;   e_acc1 = 32'h1120A;
`endif
    spi_read(96, 1'b1);
    spi_end();
    chk("snapen_r1_cnt",  96'(cap_a[95:72]), 96'(e_cnt));
    chk("snapen_r1_acc0", 96'(cap_a[39:8]),  96'(e_acc0));
    chk("snapen_r1_acc1", 96'(cap_a[71:40]), 96'(e_acc1));
    drive(2, 12'h007, 12'h000, 2'b00);
`ifdef CLEAR_ON_READ_EN
    e_cnt = 24'd3;    e_acc0 = 32'h13;
`else
    e_cnt = 24'h11F;  e_acc0 = 32'h149F8;
`endif
    spi_read(96, 1'b0);
    spi_end();
    chk("snapen_r2_cnt",  96'(cap_a[95:72]), 96'(e_cnt));
    chk("snapen_r2_acc0", 96'(cap_a[39:8]),  96'(e_acc0));

    for (int k = 0; k < 4; k++) begin
      bus_a.sck = 1'b1;
      cycles(8);
      chk($sformatf("idle_sck%0d_miso", k), 96'({bus_a.miso, bus_b.miso}), 96'(2'b00));
      bus_a.sck = 1'b0;
      cycles(8);
    end

    // Abort after 8 bits; next frame must be a fresh snapshot including the later sample.
`ifdef CLEAR_ON_READ_EN
    e_b8a = 8'h00; e_bcnt = 8'd1;  e_cnt = 24'd1;    e_acc0 = 32'h1;
`else
    e_b8a = 8'hFF; e_bcnt = 8'hFF; e_cnt = 24'h120;  e_acc0 = 32'h149F9;
`endif
    spi_read(8, 1'b0);
    spi_end();
    chk("abort_a_first8", 96'(cap_a[95:88]), 96'(8'h00));
    chk("abort_b_first8", 96'(cap_b[95:88]), 96'(e_b8a));
    drive(1, 12'h001, 12'h000, 2'b00);
    spi_read(96, 1'b0);
    spi_end();
    chk("fresh_a_cnt",  96'(cap_a[95:72]), 96'(e_cnt));
    chk("fresh_a_acc0", 96'(cap_a[39:8]),  96'(e_acc0));
    chk("fresh_b_cnt",  96'(cap_b[95:88]), 96'(e_bcnt));

    // Reset mid-frame with cs held low.
    drive(3, 12'h002, 12'h003, 2'b01);
    spi_read(20, 1'b0);
    rst = 1'b1;
    cycles(2);
    chk("midrst_miso", 96'({bus_a.miso, bus_b.miso}), 96'(2'b00));
    chk("midrst_leds", 96'({a_led1, a_led2, a_led3}), 96'(3'b000));
    rst = 1'b0;
    cycles(12);
    chk("midrst_hold_led3", 96'(a_led3), 96'(1'b0));
    chk("midrst_hold_miso", 96'(bus_a.miso), 96'(1'b0));
    spi_end();
    spi_read(96, 1'b0);
    spi_end();
    chk("postrst_a_frame", cap_a, 96'h0);
    chk("postrst_b_frame", cap_b, 96'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
